dmem_lsu: RTL and testbench
===========================

// Module: dmem_lsu
// PURPOSE
//  Load/store unit between the core's memory stage and the word-only dmem.
//  Accepts byte/half/word loads and stores, checks alignment and bounds, and issues aligned word accesses.
//  Performs sub-word stores as read-modify-write, sign/zero-extends loads, and returns one response per request.
//  Requests that would fault never reach dmem, so the dmem 32'hFFFFFFFF error word is never consumed.
// PARAMETERS
//  MEM_BYTES   `MEM_BYTES_DMEM   dmem size in bytes; last legal word address = MEM_BYTES-4
// PORTS
//  clk             in   1   single clock, all state on rising edge
//  rst             in   1   asynchronous, active-high reset
//  req_valid       in   1   request present
//  req_ready       out  1   unit idle, request accepted when req_valid&&req_ready
//  req_we          in   1   1=store, 0=load
//  req_size        in   2   2'b00 byte, 2'b01 half, 2'b10 word, 2'b11 illegal
//  req_unsigned    in   1   load zero-extends when 1 (ignored for word/store)
//  req_addr        in   32  byte address
//  req_wdata       in   32  store data, right-justified
//  resp_valid      out  1   one-cycle pulse, one per accepted request
//  resp_rdata      out  32  load result (0 for stores and errors)
//  resp_err        out  1   misaligned / out-of-range / illegal size
//  dmem_write_en   out  1   to dmem write_en
//  dmem_addr       out  32  to dmem addr, always word-aligned
//  dmem_write_data out  32  to dmem write_data
//  dmem_read_data  in   32  from dmem read_data, valid the cycle after the address edge
// BEHAVIOUR
//  - Clock and reset: one clock (clk); reset (rst) is asynchronous and active-high.
//  - Reset: state IDLE. resp_valid=0, resp_rdata=0, resp_err=0, dmem_write_en=0, dmem_addr=0, dmem_write_data=0.
//  - Reset mid-operation drops the request with no response. dmem_write_en falls asynchronously.
//  - req_ready = (state==IDLE). Request fields are registered at the accept edge A.
//    Inputs are ignored while busy. Back-to-back issue is allowed in the resp_valid cycle.
//  - Error check at accept: size 11; half with addr[0]; word with addr[1:0]!=0; {addr[31:2],2'b00} > MEM_BYTES-4.
//    Error -> no dmem access. resp_valid=1, resp_err=1, rdata=0 after edge A+1.
//  - States: IDLE, LD_RD, LD_DATA, ST_WR, RMW_RD, RMW_MRG, RMW_WR.
//    IDLE->(err) IDLE+resp | load LD_RD | word store ST_WR | sub-word store RMW_RD.
//  - Load: LD_RD drives dmem_addr. LD_DATA extracts the lane and extends it.
//    resp is registered at edge A+2, so the consumer samples it at A+3.
//  - Word store: ST_WR drives write_en=1 with req_wdata; the write occurs at A+1; resp after A+1.
//  - Sub-word store:
//    RMW_RD reads the word. RMW_MRG registers the merged word at A+2.
//    RMW_WR writes at A+3, with resp after A+3. Lanes not addressed are preserved.
//  - Lanes are little-endian: byte lane = addr[1:0], half lane = addr[1]. Sign bit is bit 7/15 of the selected lane.
//  - dmem_write_en is high only in ST_WR/RMW_WR, exactly one cycle per store. dmem_addr = {addr_q[31:2],2'b00}.
//  - resp_err=0 and resp_rdata=0 on successful stores. All resp fields hold their last values while resp_valid=0.
// STRUCTURE
//  - Shared header variables.vh: MEM_BYTES_DMEM, size encodings (SZ_B/SZ_H/SZ_W), FSM state encodings.
//  - One combinational sub-module, lsu_align:
//    extract(word, lane, size, unsigned) -> rdata; merge(word, wdata, lane, size) -> word.
//  - The FSM and registers live in dmem_lsu.
// TESTING (bench instantiates dmem_lsu + dmem, MEM_BYTES=1024)
//  1. Word store 0x0000_0010 <- 0xDEADBEEF, then LW 0x10 -> rdata 0xDEADBEEF.
//     Store resp at A+1, load resp at A+2, err=0.
//  2. After test 1: SB 0x11 <- 0x55 then LW 0x10 -> 0xDEAD55EF.
//     LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE.
//  3. SH 0x12 <- 0x8001 then LH 0x12 -> 0xFFFF8001, LHU 0x12 -> 0x00008001.
//     Exactly one dmem_write_en pulse per store.
//  4. LW 0x13, LH 0x11, size 2'b11, LW 0x400, SW 0x3FC:
//     first four give resp_err=1, rdata=0, no write_en. SW 0x3FC succeeds.
//  5. Assert rst in RMW_RD of SB 0x20 <- 0xAA (word 0x20 preloaded 0x11223344):
//     no resp, write_en stays 0, mem[0x20] still 0x11223344. Next request is accepted normally.
//  6. Back-to-back: req_valid held high with 8 mixed ops.
//     Exactly 8 resp pulses in order; req_ready low throughout every busy state.

Source files
------------

// File: rtl/dmem_lsu_pkg.sv
// Shared definitions for the load/store unit: dmem size, access-size
// encodings, FSM states and the request fault check.
package dmem_lsu_pkg;

  // Default dmem size in bytes; last legal word address is MEM_BYTES_DMEM-4.
  localparam int MEM_BYTES_DMEM = 1024;

  // Access size encodings carried on req_size.
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;

  // FSM states. IDLE is the only state in which a request is accepted.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LD_RD   = 3'd1,
    S_LD_DATA = 3'd2,
    S_ST_WR   = 3'd3,
    S_RMW_RD  = 3'd4,
    S_RMW_MRG = 3'd5,
    S_RMW_WR  = 3'd6
  } state_e;

  // A request faults on an illegal size, a misaligned half/word, or a word
  // address past the last legal word. Faulting requests never reach dmem.
  function automatic logic req_fault(input logic [1:0]  size,
                                     input logic [31:0] addr,
                                     input logic [31:0] last_word);
    logic f;
    f = 1'b0;
    if (size == SZ_X)                        f = 1'b1;
    if ((size == SZ_H) && addr[0])           f = 1'b1;
    if ((size == SZ_W) && (addr[1:0] != 2'b00)) f = 1'b1;
    if ({addr[31:2], 2'b00} > last_word)     f = 1'b1;
    return f;
  endfunction

endpackage

// File: rtl/dmem_lsu_align.sv
// Combinational lane logic: extracts and extends a load lane from a dmem
// word, and merges right-justified store data into a dmem word.
module lsu_align
  import dmem_lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [31:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte and half lanes (little-endian).
  always_comb begin
    byte_sel = word[7:0];
    case (lane)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = lane[1] ? word[31:16] : word[15:0];
  end

  // Sign- or zero-extend the selected lane; words pass straight through.
  always_comb begin
    rdata = word;
    case (size)
      SZ_B:    rdata = is_unsigned ? {24'h0, byte_sel}
                                   : {{24{byte_sel[7]}}, byte_sel};
      SZ_H:    rdata = is_unsigned ? {16'h0, half_sel}
                                   : {{16{half_sel[15]}}, half_sel};
      default: rdata = word;
    endcase
  end

  // Replace only the addressed lane; every other lane keeps the old word.
  always_comb begin
    merged = wdata;
    case (size)
      SZ_B: begin
        case (lane)
          2'd0:    merged = {word[31:8], wdata[7:0]};
          2'd1:    merged = {word[31:16], wdata[7:0], word[7:0]};
          2'd2:    merged = {word[31:24], wdata[7:0], word[15:0]};
          default: merged = {wdata[7:0], word[23:0]};
        endcase
      end
      SZ_H:    merged = lane[1] ? {wdata[15:0], word[15:0]}
                                : {word[31:16], wdata[15:0]};
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit between the memory stage and a word-only dmem.
// Handshake: a request transfers on a rising edge where req_valid && req_ready;
// req_ready is high only in IDLE, so request inputs are ignored while busy.
// Each accepted request yields exactly one single-cycle resp_valid pulse,
// except when rst aborts it. Faulting requests respond without touching dmem.
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int MEM_BYTES = MEM_BYTES_DMEM
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        dmem_write_en,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_write_data,
  input  logic [31:0] dmem_read_data
);

  localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

  state_e      state_q, state_d;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;
  logic        resp_err_q;
  logic        accept;
  logic        fault;
  logic [31:0] ext_rdata;
  logic [31:0] merged_word;

  assign req_ready = (state_q == S_IDLE);
  assign accept    = req_valid && req_ready;
  assign fault     = req_fault(req_size, req_addr, LAST_WORD);

  assign dmem_addr       = {addr_q[31:2], 2'b00};
  assign dmem_write_data = wdata_q;
  assign resp_valid      = resp_valid_q;
  assign resp_rdata      = resp_rdata_q;
  assign resp_err        = resp_err_q;

  lsu_align u_align (
    .word        (dmem_read_data),
    .lane        (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .wdata       (wdata_q),
    .rdata       (ext_rdata),
    .merged      (merged_word)
  );

  // State register; reset forces IDLE so write_en drops immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state and the dmem write strobe.
  always_comb begin
    state_d       = state_q;
    dmem_write_en = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept && !fault) begin
          if (!req_we)              state_d = S_LD_RD;
          else if (req_size == SZ_W) state_d = S_ST_WR;
          else                      state_d = S_RMW_RD;
        end
      end
      S_LD_RD:   state_d = S_LD_DATA;
      S_LD_DATA: state_d = S_IDLE;
      S_ST_WR: begin
        dmem_write_en = 1'b1;
        state_d       = S_IDLE;
      end
      S_RMW_RD:  state_d = S_RMW_MRG;
      S_RMW_MRG: state_d = S_RMW_WR;
      S_RMW_WR: begin
        dmem_write_en = 1'b1;
        state_d       = S_IDLE;
      end
      default:   state_d = S_IDLE;
    endcase
  end

  // Request capture at accept; wdata_q later holds the merged RMW word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      size_q  <= SZ_B;
      uns_q   <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
    end else if (accept) begin
      size_q  <= req_size;
      uns_q   <= req_unsigned;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end else if (state_q == S_RMW_MRG) begin
      wdata_q <= merged_word;
    end
  end

  // Response pulse; rdata/err hold their last values between pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      if (accept && fault) begin
        resp_valid_q <= 1'b1;
        resp_rdata_q <= 32'h0;
        resp_err_q   <= 1'b1;
      end else if (state_q == S_LD_DATA) begin
        resp_valid_q <= 1'b1;
        resp_rdata_q <= ext_rdata;
        resp_err_q   <= 1'b0;
      end else if ((state_q == S_ST_WR) || (state_q == S_RMW_WR)) begin
        resp_valid_q <= 1'b1;
        resp_rdata_q <= 32'h0;
        resp_err_q   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu with a behavioural 1 KiB synchronous-read dmem.
module tb_dmem_lsu;
  import dmem_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        dmem_write_en;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_write_data;
  logic [31:0] dmem_read_data;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  dmem_lsu #(.MEM_BYTES(1024)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_we          (req_we),
    .req_size        (req_size),
    .req_unsigned    (req_unsigned),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_err        (resp_err),
    .dmem_write_en   (dmem_write_en),
    .dmem_addr       (dmem_addr),
    .dmem_write_data (dmem_write_data),
    .dmem_read_data  (dmem_read_data)
  );

  // ---------------- dmem model ----------------
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (dmem_write_en) mem[dmem_addr[9:2]] <= dmem_write_data;
    dmem_read_data <= (dmem_addr < 32'd1024) ? mem[dmem_addr[9:2]] : 32'hFFFFFFFF;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_wr = 0;
  always @(negedge clk) if (dmem_write_en) n_wr++;

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  logic        exp_err_q[$];
  int          exp_lat_q[$];
  int          acc_q[$];
  int n_cmp = 0;
  int n_fail = 0;
  int n_resp = 0;
  int busy_viol = 0;
  int exp_wr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare each response against the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (resp_valid) begin
        n_resp++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_resp: got rdata %h err %b with nothing outstanding", resp_rdata, resp_err);
        end else begin
          logic [31:0] e_rd;
          logic        e_err;
          int          e_lat, a_cyc;
          e_rd  = exp_q.pop_front();
          e_err = exp_err_q.pop_front();
          e_lat = exp_lat_q.pop_front();
          a_cyc = acc_q.pop_front();
          check("resp_rdata", resp_rdata, e_rd);
          check("resp_err", {31'h0, resp_err}, {31'h0, e_err});
          check("resp_latency", 32'(cyc - a_cyc - 1), 32'(e_lat));
        end
      end else if (exp_q.size() > 0 && req_ready) begin
        busy_viol++;
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          lat;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic we, input logic [1:0] size, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rdata, input logic exp_err, input int lat);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.lat = lat;
    vq.push_back(v);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input vec_t v);
    int t;
    int a_cyc;
    @(negedge clk);
    req_we = v.we; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata; req_valid = 1'b1;
    t = 0;
    while (!req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: got req_ready 0 expected 1 for addr %h", v.addr);
      return;
    end
    a_cyc = cyc;
    @(posedge clk);
    exp_q.push_back(v.exp_rdata);
    exp_err_q.push_back(v.exp_err);
    exp_lat_q.push_back(v.lat);
    acc_q.push_back(a_cyc);
    if (v.we && !v.exp_err) exp_wr++;
  endtask

  task automatic drain();
    int t;
    @(negedge clk);
    req_valid = 1'b0;
    t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d outstanding expected 0", exp_q.size());
      exp_q.delete(); exp_err_q.delete(); exp_lat_q.delete(); acc_q.delete();
    end
  endtask

  task automatic run(input int lo, input int hi, input bit b2b);
    for (int i = lo; i <= hi; i++) begin
      drive(vq[i]);
      if (!b2b) drain();
    end
    drain();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int resp_base;
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = SZ_W; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;

    // Table: we size uns addr wdata exp_rdata exp_err latency
    // 0-1: word store then load
    add(1, SZ_W, 0, 32'h10, 32'hDEADBEEF, 32'h0,        0, 1);
    add(0, SZ_W, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0, 2);
    // 2-5: byte store, loads
    add(1, SZ_B, 0, 32'h11, 32'h00000055, 32'h0,        0, 3);
    add(0, SZ_W, 0, 32'h10, 32'h0,        32'hDEAD55EF, 0, 2);
    add(0, SZ_B, 0, 32'h13, 32'h0,        32'hFFFFFFDE, 0, 2);
    add(0, SZ_B, 1, 32'h13, 32'h0,        32'h000000DE, 0, 2);
    // 6-9: half store, loads
    add(1, SZ_H, 0, 32'h12, 32'h00008001, 32'h0,        0, 3);
    add(0, SZ_H, 0, 32'h12, 32'h0,        32'hFFFF8001, 0, 2);
    add(0, SZ_H, 1, 32'h12, 32'h0,        32'h00008001, 0, 2);
    add(0, SZ_W, 0, 32'h10, 32'h0,        32'h800155EF, 0, 2);
    // 10-17: faults and the top-of-memory boundary
    add(0, SZ_W, 0, 32'h13, 32'h0,        32'h0,        1, 0);
    add(0, SZ_H, 0, 32'h11, 32'h0,        32'h0,        1, 0);
    add(0, SZ_X, 0, 32'h10, 32'h0,        32'h0,        1, 0);
    add(0, SZ_W, 0, 32'h400, 32'h0,       32'h0,        1, 0);
    add(1, SZ_B, 0, 32'h400, 32'hFF,      32'h0,        1, 0);
    add(1, SZ_W, 0, 32'h3FC, 32'h12345678, 32'h0,       0, 1);
    add(0, SZ_W, 0, 32'h3FC, 32'h0,       32'h12345678, 0, 2);
    add(0, SZ_B, 0, 32'h3FF, 32'h0,       32'h00000012, 0, 2);
    // 18-19: after the aborted RMW
    add(0, SZ_W, 0, 32'h20, 32'h0,        32'h11223344, 0, 2);
    add(0, SZ_W, 0, 32'h10, 32'h0,        32'h800155EF, 0, 2);
    // 20-27: back-to-back mix
    add(1, SZ_W, 0, 32'h40, 32'hCAFEF00D, 32'h0,        0, 1);
    add(0, SZ_W, 0, 32'h40, 32'h0,        32'hCAFEF00D, 0, 2);
    add(1, SZ_B, 0, 32'h42, 32'h00000080, 32'h0,        0, 3);
    add(0, SZ_B, 0, 32'h42, 32'h0,        32'hFFFFFF80, 0, 2);
    add(0, SZ_H, 0, 32'h43, 32'h0,        32'h0,        1, 0);
    add(1, SZ_H, 0, 32'h40, 32'h00001234, 32'h0,        0, 3);
    add(0, SZ_H, 1, 32'h42, 32'h0,        32'h0000CA80, 0, 2);
    add(0, SZ_W, 0, 32'h40, 32'h0,        32'hCA801234, 0, 2);

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_resp_err", {31'h0, resp_err}, 32'h0);
    check("rst_write_en", {31'h0, dmem_write_en}, 32'h0);
    check("rst_dmem_addr", dmem_addr, 32'h0);
    check("rst_dmem_wdata", dmem_write_data, 32'h0);
    check("rst_req_ready", {31'h0, req_ready}, 32'h1);

    run(0, 1, 0);
    check("wr_pulses_t1", 32'(n_wr), 32'(exp_wr));
    run(2, 5, 0);
    check("wr_pulses_t2", 32'(n_wr), 32'(exp_wr));
    run(6, 9, 0);
    check("wr_pulses_t3", 32'(n_wr), 32'(exp_wr));
    run(10, 17, 0);
    check("wr_pulses_t4", 32'(n_wr), 32'(exp_wr));
    check("mem_3fc", mem[255], 32'h12345678);

    // Reset during RMW_RD of SB 0x20 <- 0xAA.
    mem[8] = 32'h11223344;
    @(negedge clk);
    req_we = 1'b1; req_size = SZ_B; req_unsigned = 1'b0;
    req_addr = 32'h20; req_wdata = 32'h000000AA; req_valid = 1'b1;
    check("t5_ready", {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("t5_busy", {31'h0, req_ready}, 32'h0);
    rst = 1'b1;
    #1;
    check("t5_rst_write_en", {31'h0, dmem_write_en}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    resp_base = n_resp;
    repeat (4) begin
      @(negedge clk);
      check("t5_write_en", {31'h0, dmem_write_en}, 32'h0);
    end
    check("t5_no_resp", 32'(n_resp - resp_base), 32'h0);
    check("t5_mem_20", mem[8], 32'h11223344);
    check("wr_pulses_t5", 32'(n_wr), 32'(exp_wr));
    run(18, 19, 0);

    // Back-to-back with req_valid held high.
    resp_base = n_resp;
    run(20, 27, 1);
    check("t6_resp_count", 32'(n_resp - resp_base), 32'd8);
    check("wr_pulses_t6", 32'(n_wr), 32'(exp_wr));
    check("mem_40", mem[16], 32'hCA801234);
    check("busy_ready_low", 32'(busy_viol), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

  // Global time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
